// File: rtl/lsu_subword.sv
// lsu_subword: byte/halfword/word load-store adapter in front of a word-only
// data memory. Sub-word stores become read-modify-write; sub-word loads are
// sign/zero-extended. Misaligned or illegal requests answer with resp_err.
module lsu_subword #(
  parameter int CPU_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [CPU_WIDTH-1:0] req_addr,
  input  logic [CPU_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [CPU_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [CPU_WIDTH-1:0] mem_addr,
  output logic [CPU_WIDTH-1:0] mem_wdata,
  output logic                 mem_write_en,
  output logic                 mem_read_en,
  input  logic [CPU_WIDTH-1:0] mem_rdata
);
  localparam int NUM_LANES = CPU_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, ERR} state_t;

  typedef struct packed {
    logic [CPU_WIDTH-1:0] addr;
    logic [2:0]           funct3;
  } req_t;

  state_t                    state, state_nx;
  req_t                      req_q;
  logic [CPU_WIDTH-1:0]      merge_q;   // store data at accept, merged word after RMW_RD
  logic                      accept, illegal, misalign, sign;
  logic [NUM_LANES-1:0][7:0] rd_lanes, st_lanes, merged;
  logic [NUM_LANES-1:0]      lane_we;
  logic [CPU_WIDTH-1:0]      shifted, load_ext;

  assign accept = req_valid & req_ready;

  // Decode illegal size codes and alignment faults on the incoming request
  always_comb begin
    illegal = 1'b0;
    if (req_we) illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else        illegal = (req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110);
    misalign = illegal
             | ((req_funct3[1:0] == 2'b01) & req_addr[0])
             | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  // Next-state: stores of a full word skip the read, sub-word stores do RMW
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        if (misalign)                       state_nx = ERR;
        else if (!req_we)                   state_nx = RD;
        else if (req_funct3[1:0] == 2'b10)  state_nx = WR;
        else                                state_nx = RMW_RD;
      end
      RMW_RD:      state_nx = WR;
      RD, WR, ERR: state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight RMW before its write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Memory-side strobes and address are pure state decodes (quiet in IDLE)
  always_comb begin
    req_ready    = (state == IDLE);
    mem_read_en  = (state == RD) | (state == RMW_RD);
    mem_write_en = (state == WR);
    mem_addr     = (state == IDLE) ? '0 : {req_q.addr[CPU_WIDTH-1:2], 2'b00};
    mem_wdata    = (state == WR) ? merge_q : '0;
  end

  // Byte-lane merge of the store data into the read word (little-endian)
  assign rd_lanes = mem_rdata;
  assign st_lanes = merge_q;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_we[k] = req_q.funct3[0] ? (req_q.addr[1] == ((k / 2) % 2 == 1))
                                        : (req_q.addr[1:0] == 2'(k));
    assign merged[k]  = lane_we[k] ? (req_q.funct3[0] ? st_lanes[k % 2] : st_lanes[0])
                                   : rd_lanes[k];
  end

  // Load lane select and extension; funct3[2] set means unsigned
  always_comb begin
    sign     = ~req_q.funct3[2];
    shifted  = mem_rdata >> {req_q.addr[1:0], 3'b000};
    case (req_q.funct3[1:0])
      2'b00:   load_ext = {{(CPU_WIDTH-8){sign & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{(CPU_WIDTH-16){sign & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Capture the request on accept; merge register is reused for SW data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      merge_q <= '0;
    end else if (accept) begin
      req_q   <= '{addr: req_addr, funct3: req_funct3};
      merge_q <= req_wdata;
    end else if (state == RMW_RD) begin
      merge_q <= merged;
    end
  end

  // Registered response pulse; load data holds until the next load completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state == RD) | (state == WR) | (state == ERR);
      resp_err   <= (state == ERR);
      if (state == RD) resp_rdata <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// tb_lsu_subword: table-driven vectors against a word memory model, with a
// scoreboard queue of expected responses plus reset-abort and back-to-back runs.
module tb_lsu_subword;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write_en, mem_read_en;

  lsu_subword #(.CPU_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write on rising edge
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write_en) mem[mem_addr[7:2]] <= mem_wdata;

  // Strobe counters sampled mid-cycle
  int rd_cnt = 0, wr_cnt = 0;
  always @(negedge clk) begin
    rd_cnt += int'(mem_read_en);
    wr_cnt += int'(mem_write_en);
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;   // load result, or memory word after a store
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  int errors = 0, checks = 0, n_resp = 0;
  logic [31:0] last_load = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pop and compare one response if the DUT is presenting one
  task automatic service();
    exp_t e;
    if (resp_valid) begin
      n_resp++;
      if (sb.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        if (e.chk_rd) chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic err,
                              input int lat, input int nrd, input int nwr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = err;
    v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int rd0, wr0, lat;
    bit done;
    @(negedge clk);
    req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    if (v.err)       e = '{rdata: last_load, err: 1'b1, chk_rd: 1'b1};
    else if (!v.we)  e = '{rdata: v.rdata,   err: 1'b0, chk_rd: 1'b1};
    else             e = '{rdata: 32'h0,     err: 1'b0, chk_rd: 1'b0};
    if (!v.err && !v.we) last_load = v.rdata;
    sb.push_back(e);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    lat = 0; done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (resp_valid) begin
        service();
        done = 1;
      end
    end
    if (!done) begin
      chk($sformatf("timeout_v%0d", idx), 32'd1, 32'd0);
      sb.delete();
    end
    chk($sformatf("latency_v%0d", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("rd_strobes_v%0d", idx), 32'(rd_cnt - rd0), 32'(v.nrd));
    chk($sformatf("wr_strobes_v%0d", idx), 32'(wr_cnt - wr0), 32'(v.nwr));
    if (v.we && !v.err) chk($sformatf("mem_word_v%0d", idx), mem[v.addr[7:2]], v.rdata);
  endtask

  vec_t vecs[22];
  vec_t b2b[3];

  initial begin
    int idx, wr0, resp0;
    bit acc;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    mem[4] <= 32'h8899AABB;
    mem[6] <= 32'h11223344;

    //          we  f3     addr   wdata          rdata/word     err lat rd wr
    vecs[0]  = mk(0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAA, 0, 2, 1, 0);
    vecs[1]  = mk(0, 3'b100, 32'h13, 32'h0,        32'h00000088, 0, 2, 1, 0);
    vecs[2]  = mk(0, 3'b001, 32'h12, 32'h0,        32'hFFFF8899, 0, 2, 1, 0);
    vecs[3]  = mk(1, 3'b000, 32'h12, 32'h12345677, 32'h8877AABB, 0, 3, 1, 1);
    vecs[4]  = mk(0, 3'b010, 32'h10, 32'h0,        32'h8877AABB, 0, 2, 1, 0);
    vecs[5]  = mk(1, 3'b001, 32'h10, 32'hDEADCAFE, 32'h8877CAFE, 0, 3, 1, 1);
    vecs[6]  = mk(0, 3'b101, 32'h12, 32'h0,        32'h00008877, 0, 2, 1, 0);
    vecs[7]  = mk(1, 3'b010, 32'h14, 32'h01020304, 32'h01020304, 0, 2, 0, 1);
    vecs[8]  = mk(0, 3'b000, 32'h14, 32'h0,        32'h00000004, 0, 2, 1, 0);
    vecs[9]  = mk(0, 3'b001, 32'h16, 32'h0,        32'h00000102, 0, 2, 1, 0);
    vecs[10] = mk(1, 3'b000, 32'h17, 32'h000000FF, 32'hFF020304, 0, 3, 1, 1);
    vecs[11] = mk(0, 3'b000, 32'h17, 32'h0,        32'hFFFFFFFF, 0, 2, 1, 0);
    vecs[12] = mk(0, 3'b100, 32'h17, 32'h0,        32'h000000FF, 0, 2, 1, 0);
    vecs[13] = mk(0, 3'b001, 32'h11, 32'h0,        32'h0,        1, 2, 0, 0);
    vecs[14] = mk(1, 3'b010, 32'h16, 32'h0,        32'h0,        1, 2, 0, 0);
    vecs[15] = mk(0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 2, 0, 0);
    vecs[16] = mk(1, 3'b100, 32'h10, 32'h0,        32'h0,        1, 2, 0, 0);
    vecs[17] = mk(0, 3'b010, 32'h12, 32'h0,        32'h0,        1, 2, 0, 0);
    vecs[18] = mk(1, 3'b001, 32'h13, 32'h0,        32'h0,        1, 2, 0, 0);
    vecs[19] = mk(0, 3'b111, 32'h10, 32'h0,        32'h0,        1, 2, 0, 0);
    vecs[20] = mk(1, 3'b001, 32'h16, 32'h0000BEEF, 32'hBEEF0304, 0, 3, 1, 1);
    vecs[21] = mk(0, 3'b001, 32'h16, 32'h0,        32'hFFFFBEEF, 0, 2, 1, 0);

    // Reset state
    #12;
    chk("rst_req_ready",  {31'd0, req_ready},    32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid},   32'd0);
    chk("rst_resp_err",   {31'd0, resp_err},     32'd0);
    chk("rst_resp_rdata", resp_rdata,            32'd0);
    chk("rst_mem_we",     {31'd0, mem_write_en}, 32'd0);
    chk("rst_mem_re",     {31'd0, mem_read_en},  32'd0);
    chk("rst_mem_addr",   mem_addr,              32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) run_vec(vecs[i], i);

    // Reset while an SB sits in RMW_RD: no write, block idle immediately
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h19; req_wdata = 32'h000000AB;
    req_valid = 1'b1;
    wr0 = wr_cnt; resp0 = n_resp;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_rd_strobe", {31'd0, mem_read_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_req_ready", {31'd0, req_ready},    32'd1);
    chk("abort_mem_we",    {31'd0, mem_write_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      service();
    end
    chk("abort_mem_word", mem[6], 32'h11223344);
    chk("abort_wr_count", 32'(wr_cnt - wr0), 32'd0);
    chk("abort_no_resp",  32'(n_resp - resp0), 32'd0);
    last_load = 32'h0;   // reset cleared resp_rdata

    // Back-to-back LW, SB, LW with req_valid held high
    b2b[0] = mk(0, 3'b010, 32'h10, 32'h0,        32'h8877CAFE, 0, 0, 0, 0);
    b2b[1] = mk(1, 3'b000, 32'h10, 32'h00000055, 32'h0,        0, 0, 0, 0);
    b2b[2] = mk(0, 3'b010, 32'h10, 32'h0,        32'h8877CA55, 0, 0, 0, 0);
    resp0 = n_resp;
    idx = 0;
    @(negedge clk);
    req_we = b2b[0].we; req_funct3 = b2b[0].f3; req_addr = b2b[0].addr; req_wdata = b2b[0].wdata;
    req_valid = 1'b1;
    for (int c = 0; c < 40 && (idx < 3 || sb.size() > 0); c++) begin
      acc = req_valid && req_ready;
      if (acc) sb.push_back('{rdata: b2b[idx].rdata, err: 1'b0, chk_rd: !b2b[idx].we});
      @(posedge clk);
      @(negedge clk);
      service();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          req_we = b2b[idx].we; req_funct3 = b2b[idx].f3;
          req_addr = b2b[idx].addr; req_wdata = b2b[idx].wdata;
        end else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts",   32'(idx), 32'd3);
    chk("b2b_responses", 32'(n_resp - resp0), 32'd3);
    chk("b2b_drained",   32'(sb.size()), 32'd0);
    chk("b2b_mem_word",  mem[4], 32'h8877CA55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
